pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage 64-bit RISC-V pipeline. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enable and flush controls plus the PC enable and select. It arbitrates three hazard sources by fixed priority:

- data-memory wait (multi-cycle memory),
- taken-branch redirect (resolved in MEM),
- load-use stall.

It also keeps saturating performance counters and traps a hung memory access.

## Interface
Parameters:
- MEM_TIMEOUT, 64: number of consecutive wait cycles that forces the ERR state.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source register addresses of the instruction in decode.
- id_use_rs1, id_use_rs2  in  1 each  decode instruction actually reads rs1 / rs2.
- ex_rd  in  5  ID/EX destination register.
- ex_mem_read  in  1  ID/EX instruction is a load.
- mem_branch_taken  in  1  EX/MEM Branch & Zero.
- mem_access  in  1  EX/MEM MemRead | MemWrite.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, pc_sel  out  1 each  PC update enable; PC select (1 = branch target).
- if_id_en, if_id_flush  out  1 each  IF/ID enable / zero-to-NOP.
- id_ex_en, id_ex_flush  out  1 each  ID/EX enable / bubble.
- ex_mem_en, ex_mem_flush  out  1 each  EX/MEM enable / bubble.
- mem_wb_bubble  out  1  MEM/WB loads a NOP (RegWrite=0).
- stall_cycles, flush_count  out  CNT_W each  saturating counters.
- state_o  out  2  current FSM state.
- mem_timeout_err  out  1  sticky error flag.

## Operation
- **Priority:** reset > ERR > memory wait > branch > load-use > normal.
- **Normal (RUN, no hazard):**
  - all `*_en` = 1.
  - all flushes, `pc_sel` and `mem_wb_bubble` = 0.
- **Memory wait:** `mem_access` & !`mem_ready` in RUN or MEM_WAIT.
  - Freeze: `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `mem_wb_bubble` = 1.
  - Any pending branch or load-use action is suppressed; it re-evaluates on release.
- **Branch redirect:** `mem_branch_taken` with no memory wait.
  - `pc_sel` = 1, `pc_en` = 1.
  - `if_id_flush`, `id_ex_flush`, `ex_mem_flush` = 1, squashing the 3 younger instructions.
  - `flush_count` += 1.
- **Load-use:** `ex_mem_read` & `ex_rd` != 0 & ((`id_use_rs1` & `id_rs1` == `ex_rd`) | (`id_use_rs2` & `id_rs2` == `ex_rd`)).
  - `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1; `ex_mem_en` = 1.
  - Clears itself the next cycle because the bubble leaves `ex_mem_read` = 0.
- **FSM states:** RUN=0, MEM_WAIT=1, ERR=2.
  - RUN -> MEM_WAIT on a memory wait; `wait_cnt` <= 1.
  - MEM_WAIT: `wait_cnt` += 1 each cycle `mem_ready` is low.
  - MEM_WAIT -> RUN when `mem_ready` = 1. That cycle is a normal release: all enables = 1 and MEM/WB captures the data.
  - MEM_WAIT -> ERR when `wait_cnt` == MEM_TIMEOUT with `mem_ready` still low.
  - ERR: full freeze as in memory wait, `mem_timeout_err` = 1. Left only by reset.
- **`stall_cycles`:** +1 on every cycle with `pc_en` = 0, excluding ERR and reset.
- **Counters:** both saturate at 2^CNT_W-1, with no wrap.

## Timing
- All control outputs are combinational from the current state and inputs, so they act in the same cycle. State, counters and the error flag are registered.
- Load-use penalty: exactly 1 bubble cycle.
- Branch penalty: 3 squashed slots. The redirect target is latched on the same edge that flushes.
- Memory wait: stall length equals the number of cycles with `mem_ready` low. Zero extra cycles on release.
- **Reset asserted** (asynchronous, any time, including mid-wait):
  - state = RUN, `wait_cnt` = 0, counters = 0, `mem_timeout_err` = 0.
  - Outputs while reset is high: all `*_en` = 0, all flushes = 0, `pc_sel` = 0, `mem_wb_bubble` = 1.
  - Normal operation starts on the first edge after deassertion.
- `mem_access` & `mem_branch_taken` together: the memory wait wins. The branch is applied on the release cycle, because EX/MEM is held.
- `ex_rd` = 0 never stalls.

## Structure
- Package `pipeline_ctrl_pkg`:
  - state encoding constants RUN/MEM_WAIT/ERR.
  - `CNT_W` default.
  - helper function for a saturating increment.
- Sub-module `load_use_detect`: purely combinational comparator, outputs `lu_stall`.
- FSM, priority mux and counters live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_use_rs2` = 1 -> one cycle of `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1; the next cycle is normal; `stall_cycles` = 1.
- **Load-use to x0:** `ex_rd` = 0, `id_rs1` = 0 -> no stall.
- **Branch:** `mem_branch_taken` pulse -> `pc_sel` = 1 and three flushes for 1 cycle; `flush_count` = 1.
- **Memory wait:** `mem_access` = 1 with `mem_ready` low for 4 cycles -> 4 freeze cycles with `mem_wb_bubble` = 1, then release; `state_o` goes 1 then 0; `stall_cycles` += 4.
- **Memory timeout:** MEM_TIMEOUT = 8, `mem_ready` held low -> ERR after 8 cycles, `mem_timeout_err` = 1, freeze persists; reset mid-ERR clears all.
- **Simultaneous hazards:** memory wait + branch + load-use together -> freeze only. On release the branch flush fires and the load-use stall is squashed.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and helpers for the 5-stage pipeline stall/flush sequencer.
//   - state_t    : sequencer FSM encoding (RUN / MEM_WAIT / ERR), also the
//                  value seen on state_o.
//   - CNT_W_DEF  : default performance counter width.
//   - MAX_CNT_W  : widest counter the saturating helper supports.
//   - sat_inc()  : saturating increment against a caller-supplied ceiling.
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int MAX_CNT_W = 64;

    // Counters narrower than MAX_CNT_W are zero-extended by the caller and
    // pass their own all-ones value as the ceiling.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] v,
        input logic [MAX_CNT_W-1:0] max_v
    );
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the pipeline datapath and the stall/flush sequencer.
//   Hazard inputs (to the sequencer):
//     id_rs1/id_rs2, id_use_rs1/id_use_rs2 : decode source regs and usage
//     ex_rd, ex_mem_read                   : ID/EX destination, load flag
//     mem_branch_taken, mem_access         : EX/MEM branch and memory op
//     mem_ready                            : data memory done this cycle
//   Controls (from the sequencer):
//     pc_en, pc_sel, *_en, *_flush, mem_wb_bubble
//   Status: stall_cycles, flush_count, state_o, mem_timeout_err
//   Modports: slave = sequencer side, master = pipeline side.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int CNT_W = pipeline_ctrl_pkg::CNT_W_DEF
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             mem_branch_taken;
    logic             mem_access;
    logic             mem_ready;

    logic             pc_en;
    logic             pc_sel;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             ex_mem_flush;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       state_o;
    logic             mem_timeout_err;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, mem_access, mem_ready,
        output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_bubble,
               stall_cycles, flush_count, state_o, mem_timeout_err
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, mem_access, mem_ready,
        input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_bubble,
               stall_cycles, flush_count, state_o, mem_timeout_err
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard comparator. Flags when the instruction in
//   decode reads the destination of a load currently in EX.
//   Inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read
//   Output : lu_stall
// ----------------------------------------------------------------------------
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu_stall
);

    logic hit_rs1;
    logic hit_rs2;
    logic rd_live;

    // x0 is hardwired zero, so a load targeting it never produces a value
    // anyone waits for.
    assign rd_live  = (ex_rd != 5'd0);
    assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
    assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu_stall = ex_mem_read && rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//   Priority: reset > ERR > memory wait > branch redirect > load-use > run.
//   Ports:
//     clk, reset  : rising-edge clock, async active-high reset
//     bus (slave) : hazard inputs, register enables/flushes, PC controls,
//                   saturating stall/flush counters, FSM state, timeout flag
//   Parameters:
//     MEM_TIMEOUT : consecutive memory wait cycles that trap into ERR
//     CNT_W       : performance counter width (<= MAX_CNT_W)
//   Controls are combinational from state and inputs; state, wait count,
//   counters and the error flag are registered.
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_ctrl_if.slave       bus
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MAX_CNT_W-1:0] CNT_MAX =
        (CNT_W >= MAX_CNT_W) ? {MAX_CNT_W{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               err_q, err_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic lu_stall;
    logic mem_wait;
    logic freeze;

    load_use_detect u_lu (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .lu_stall    (lu_stall)
    );

    // A pending access only stalls while the FSM can still service it;
    // in ERR the freeze comes from the state alone.
    assign mem_wait = bus.mem_access && !bus.mem_ready && (state_q != ERR);
    assign freeze   = (state_q == ERR) || mem_wait;

    // ------------------------------------------------------------------
    // Priority mux for the pipeline controls
    // ------------------------------------------------------------------
    logic pc_en, pc_sel;
    logic if_id_en, if_id_flush;
    logic id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush;
    logic mem_wb_bubble;
    logic redirect;

    always_comb begin
        pc_en         = 1'b1;
        pc_sel        = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        redirect      = 1'b0;

        if (reset) begin
            // Hold every register and keep WB from committing while the
            // reset is in progress.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            // EX/MEM is held, so a branch or load-use seen now will still be
            // present on the release cycle and gets handled then.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (bus.mem_branch_taken) begin
            // Squash IF, ID and EX; the target is loaded on this same edge.
            pc_sel        = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            redirect      = 1'b1;
        end else if (lu_stall) begin
            // One bubble into EX; the bubble clears ex_mem_read next cycle.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_flush   = 1'b1;
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.pc_sel        = pc_sel;
    assign bus.if_id_en      = if_id_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.ex_mem_flush  = ex_mem_flush;
    assign bus.mem_wb_bubble = mem_wb_bubble;

    // ------------------------------------------------------------------
    // FSM next state and wait counter
    // ------------------------------------------------------------------
    // wait_cnt holds the number of wait cycles already completed; ERR is
    // entered on the edge that closes the MEM_TIMEOUT-th one.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    wait_cnt_d = WCNT_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    if (int'(wait_cnt_q) + 1 >= MEM_TIMEOUT) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                // Sticky until reset.
                state_d = ERR;
                err_d   = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [MAX_CNT_W-1:0] stall_inc;
    logic [MAX_CNT_W-1:0] flush_inc;
    logic                 cnt_unused;

    assign stall_inc = sat_inc(MAX_CNT_W'(stall_q), CNT_MAX);
    assign flush_inc = sat_inc(MAX_CNT_W'(flush_q), CNT_MAX);
    // Upper bits above CNT_W are always zero; fold them into a sink.
    assign cnt_unused = ^{stall_inc, flush_inc};

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        // ERR is a trap, not a stall: it is not charged to the counter.
        if (!pc_en && (state_q != ERR)) begin
            stall_d = stall_inc[CNT_W-1:0];
        end
        if (redirect) begin
            flush_d = flush_inc[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
        end
    end

    assign bus.stall_cycles    = stall_q;
    assign bus.flush_count     = flush_q;
    assign bus.state_o         = state_q;
    assign bus.mem_timeout_err = err_q;

endmodule
